// File: rtl/sfp_pkg.sv
// Shared constants and state encoding for the sfp lane and its sequencer.
package sfp_pkg;

    localparam int CNT_BW  = 8;
    localparam int PSUM_BW = 16;
    localparam int BW      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RELU  = 3'd4,
        ST_DONE  = 3'd5
    } sfp_state_e;

endpackage

// File: rtl/sfp_seq.sv
// Command sequencer for the sfp lane: clear, stream n_acc psums from the FIFO,
// optional ReLU step, then a one-cycle done pulse.
module sfp_seq
    import sfp_pkg::*;
#(
    parameter int cnt_bw = CNT_BW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_bw-1:0] n_acc,
    input  logic              relu_en,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              sfp_reset,
    output logic              sfp_acc,
    output logic              sfp_relu,
    output logic              busy,
    output logic              done,
    output logic [cnt_bw-1:0] rd_cnt
);

    sfp_state_e        state_q, state_d;
    logic [cnt_bw-1:0] n_q, n_d;
    logic              relu_q, relu_d;
    logic [cnt_bw-1:0] rd_cnt_q, rd_cnt_d;
    logic              acc_q;
    logic              rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            relu_q   <= 1'b0;
            rd_cnt_q <= '0;
            acc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            relu_q   <= relu_d;
            rd_cnt_q <= rd_cnt_d;
            acc_q    <= rd;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        relu_d   = relu_q;
        rd_cnt_d = rd_cnt_q;
        rd       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CLR;
                    n_d      = n_acc;
                    relu_d   = relu_en;
                    rd_cnt_d = '0;
                end
            end
            ST_CLR: begin
                if (n_q != '0)  state_d = ST_ACC;
                else if (relu_q) state_d = ST_RELU;
                else             state_d = ST_DONE;
            end
            ST_ACC: begin
                // Only ACC can read, and n_q >= 1 here, so n_q - 1 cannot wrap.
                rd = !fifo_empty && (rd_cnt_q < n_q);
                if (rd) begin
                    rd_cnt_d = rd_cnt_q + cnt_bw'(1);
                    if (rd_cnt_q == n_q - cnt_bw'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = relu_q ? ST_RELU : ST_DONE;
            ST_RELU:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign fifo_rd   = rd;
    assign sfp_acc   = acc_q;
    assign sfp_reset = (state_q == ST_CLR);
    assign sfp_relu  = (state_q == ST_RELU);
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_sfp_seq.sv
// Randomized bench for sfp_seq with a timeline reference model and a small
// behavioural sfp/FIFO stand-in to check accumulated results.
module tb_sfp_seq;
    localparam int CW   = 8;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] n_acc;
    logic          relu_en;
    logic          fifo_empty;
    logic          fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done;
    logic [CW-1:0] rd_cnt;

    int checks = 0;
    int errors = 0;
    int prev_n = 0;
    bit emp [0:MAXC-1];
    logic signed [15:0] words [0:1023];
    logic signed [15:0] data_q, sfp_out, res_at_done;
    int rdn = 0, base = 0;

    sfp_seq #(.cnt_bw(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .n_acc(n_acc), .relu_en(relu_en),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .sfp_reset(sfp_reset),
        .sfp_acc(sfp_acc), .sfp_relu(sfp_relu), .busy(busy), .done(done), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // FIFO + sfp stand-in: data lands the cycle after fifo_rd, sfp consumes strobes.
    always @(posedge clk) begin
        if (fifo_rd) begin
            data_q <= words[(rdn - base) % 1024];
            rdn    <= rdn + 1;
        end
        if (sfp_reset)     sfp_out <= '0;
        else if (sfp_acc)  sfp_out <= sfp_out + data_q;
        else if (sfp_relu) sfp_out <= (sfp_out < 0) ? 16'sd0 : sfp_out;
    end

    task automatic fill_emp(input int pct);
        for (int i = 0; i < MAXC; i++) emp[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic idle(input int k);
        start = 1'b0; fifo_empty = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
    endtask

    // Expected timeline from the command rules: reads take the first n
    // non-empty cycles from cycle 2; acc follows each read by one cycle;
    // done follows the last read by 2 (3 with ReLU).
    task automatic run_cmd(input string nm, input int n, input bit relu, input bit junk,
                           output int dc);
        bit isrd [0:MAXC-1];
        int k, r_last, cnt;
        logic [5:0] got, exp;
        for (int i = 0; i < MAXC; i++) isrd[i] = 1'b0;
        k = 0; r_last = 1;
        for (int c = 2; k < n && c < MAXC; c++)
            if (!emp[c]) begin isrd[c] = 1'b1; k++; r_last = c; end
        dc = ((n > 0) ? r_last + 1 : 1) + (relu ? 1 : 0) + 1;

        start = 1'b1; n_acc = CW'(n); relu_en = relu; fifo_empty = emp[0];
        base = rdn;
        @(negedge clk);
        got = {fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done};
        checks++;
        if (got !== 6'b0 || rd_cnt !== CW'(prev_n)) begin
            errors++;
            $display("FAIL %s idle c0 got %b/%0d exp 000000/%0d", nm, got, rd_cnt, prev_n);
        end
        cnt = 0;
        for (int c = 1; c <= dc; c++) begin
            @(posedge clk); #1;
            start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            n_acc = CW'($urandom); relu_en = 1'($urandom);
            fifo_empty = emp[c];
            @(negedge clk);
            exp = {isrd[c], c == 1, isrd[c-1], relu && c == dc - 1, 1'b1, c == dc};
            got = {fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s strobes c%0d got %b exp %b", nm, c, got, exp);
            end
            checks++;
            if (rd_cnt !== CW'(cnt)) begin
                errors++;
                $display("FAIL %s rd_cnt c%0d got %0d exp %0d", nm, c, rd_cnt, cnt);
            end
            if (isrd[c]) cnt++;
            if (c == dc) res_at_done = sfp_out;
        end
        @(posedge clk); #1;
        start = 1'b0; fifo_empty = 1'b0;
        prev_n = n;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; n_acc = '0; relu_en = 1'b0; fifo_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done, rd_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_held got %b/%0d exp 0", {fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done}, rd_cnt);
        end
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done, rd_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_idle got %b/%0d exp 0", {fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done}, rd_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int dc;
        fill_emp(0);
        run_cmd("basic_n4", 4, 1'b0, 1'b0, dc);
        idle(2);
    endtask

    task automatic test_relu_values;
        int dc;
        words[0] = 16'sd5; words[1] = -16'sd20; words[2] = 16'sd3;
        fill_emp(0);
        run_cmd("relu_on", 3, 1'b1, 1'b0, dc);
        checks++;
        if (res_at_done !== 16'sd0) begin
            errors++;
            $display("FAIL relu_on_value got %0d exp 0", res_at_done);
        end
        idle(1);
        run_cmd("relu_off", 3, 1'b0, 1'b0, dc);
        checks++;
        if (res_at_done !== -16'sd12) begin
            errors++;
            $display("FAIL relu_off_value got %0d exp -12", res_at_done);
        end
        idle(2);
    endtask

    task automatic test_stall;
        int dc;
        fill_emp(0);
        emp[4] = 1'b1; emp[5] = 1'b1; emp[6] = 1'b1;
        for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
        run_cmd("stall", 4, 1'b0, 1'b0, dc);
        checks++;
        if (res_at_done !== 16'sd10) begin
            errors++;
            $display("FAIL stall_sum got %0d exp 10", res_at_done);
        end
        idle(2);
    endtask

    task automatic test_zero;
        int dc;
        fill_emp(0);
        run_cmd("zero_relu", 0, 1'b1, 1'b0, dc);
        idle(1);
        run_cmd("zero_norelu", 0, 1'b0, 1'b0, dc);
        idle(2);
    endtask

    task automatic test_ignore;
        int dc;
        fill_emp(25);
        run_cmd("ignore_start", 6, 1'b1, 1'b1, dc);
        idle(1);
    endtask

    task automatic test_back_to_back;
        int dc;
        fill_emp(0);
        run_cmd("b2b_a", 2, 1'b1, 1'b0, dc);
        run_cmd("b2b_b", 3, 1'b0, 1'b0, dc);
        fill_emp(30);
        run_cmd("b2b_c", 5, 1'b1, 1'b1, dc);
        idle(2);
    endtask

    task automatic test_max;
        int dc;
        fill_emp(20);
        run_cmd("max_n", 255, 1'b1, 1'b0, dc);
        idle(2);
    endtask

    task automatic test_random;
        int dc;
        for (int i = 0; i < 10; i++) begin
            fill_emp($urandom_range(0, 50));
            for (int j = 0; j < 64; j++) words[j] = 16'($urandom);
            run_cmd("random", $urandom_range(0, 40), 1'($urandom), 1'($urandom), dc);
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
        end
        idle(1);
    endtask

    task automatic test_async_reset;
        int dc;
        start = 1'b1; n_acc = 8'd8; relu_en = 1'b1; fifo_empty = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done, rd_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b/%0d exp 0", {fifo_rd, sfp_reset, sfp_acc, sfp_relu, busy, done}, rd_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({fifo_rd, busy, done} !== 3'b0) begin
            errors++;
            $display("FAIL async_reset_edge got %b exp 000", {fifo_rd, busy, done});
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        prev_n = 0;
        fill_emp(10);
        run_cmd("after_reset", 5, 1'b1, 1'b0, dc);
        idle(2);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_relu_values;
        test_stall;
        test_zero;
        test_ignore;
        test_back_to_back;
        test_max;
        test_random;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
